hvpi_int_sequencer: RTL
=======================

# hvpi_int_sequencer

Interrupt entry/exit sequencer sitting directly downstream of the HPVI priority interrupt system. Consumes the pending flag and vectored ISR address, stalls fetch at an instruction boundary, saves the return PC on a small LIFO, and redirects the PC to the ISR. It then acknowledges the pending interrupt back to the HPVI block and restores the PC on RETI.

## Interface
- pcWidth, 16, PC / ISR address width
- stackDepth, 4, return-address LIFO entries (power of two)
- stackAddrLen, 2, log2(stackDepth)

- clk  in  1  system clock, all logic rising-edge
- rstN  in  1  synchronous, active-low reset
- intPending  in  1  pending interrupt flag from HPVI block
- intAddr  in  pcWidth  ISR vector from HPVI block
- gie  in  1  global interrupt enable from CPU status
- instrDone  in  1  CPU at instruction boundary this cycle
- pcIn  in  pcWidth  address of next instruction (return address)
- reti  in  1  single-cycle pulse, RETI decoded
- stall  out  1  hold fetch/decode
- pcLoad  out  1  single-cycle PC overwrite strobe
- pcOut  out  pcWidth  PC value when pcLoad=1, else 0
- intAck  out  1  single-cycle pulse to HPVI pendClr / clrIntReg
- intDisable  out  1  to HPVI intDisable
- inIsr  out  1  nesting level > 0
- nestLevel  out  stackAddrLen+1  current LIFO occupancy
- stackErr  out  1  sticky: RETI at level 0

## Operation
- FSM states: IDLE, ACK, VECTOR, RETURN; state register only.
- IDLE:
  - reti && nestLevel>0 -> RETURN (RETI wins over simultaneous interrupt).
  - reti && nestLevel==0 -> set stackErr, stay IDLE.
  - else intPending && gie && instrDone && !intDisable -> ACK; capture intAddr into vecReg and pcIn into retReg in this cycle.
- ACK: intAck=1, push retReg, nestLevel+1 -> VECTOR.
- VECTOR: pcLoad=1, pcOut=vecReg -> IDLE.
- RETURN: pop, pcLoad=1, pcOut=popped value, nestLevel-1 -> IDLE.
- stall = (state != IDLE).
- Once ACK entered, sequence completes regardless of gie, intPending or intAddr changes; later changes to intAddr are ignored.
- LIFO full blocks entry (via intDisable); push never occurs when full.
- nestLevel width one bit wider than stackAddrLen so full (=stackDepth) is representable.
- stackErr clears only on reset.

## Timing
- Reset (rstN=0 at clock edge): state=IDLE, nestLevel=0, stackErr=0, vecReg/retReg=0; all outputs 0 except intDisable per config formula evaluated at reset state (0).
- Reset mid-sequence aborts immediately; no pcLoad/intAck issued afterwards; LIFO contents discarded.
- Entry: qualify in cycle N; N+1 stall=1, intAck=1; N+2 stall=1, pcLoad=1, pcOut=ISR; N+3 stall=0, IDLE. Next entry qualifiable at N+3 at earliest.
- Return: reti in cycle N; N+1 stall=1, pcLoad=1, pcOut=return PC; N+2 IDLE.
- intAck and pcLoad never coincide; each exactly one cycle.

## Configuration
- Macro INT_NEST_EN.
- Defined: nesting up to stackDepth; intDisable = (state != IDLE) || (nestLevel == stackDepth).
- Undefined: single-level only; effective depth 1; intDisable = (state != IDLE) || inIsr; stackDepth ignored, LIFO reduced to one register.

## Structure
- Package hvpi_int_seq_pkg: FSM state enum, reset constants for state/registers.
- Sub-module hvpi_ret_stack: synchronous LIFO (push, pop, dataIn, dataOut, level, full, empty), parameterised by pcWidth/stackDepth; instantiated only as one register when INT_NEST_EN undefined.

## Test plan
- Basic entry: gie=1, instrDone=1, intPending=1, intAddr=0x0040, pcIn=0x1234 -> intAck at N+1, pcLoad with pcOut=0x0040 at N+2, nestLevel=1, inIsr=1.
- Return: after entry, reti pulse -> pcLoad with pcOut=0x1234 at next cycle, nestLevel=0, stall low the cycle after.
- Gating: intPending=1 with gie=0 or instrDone=0 -> no intAck, stall stays 0 for 20 cycles.
- Nesting (INT_NEST_EN): four entries with return PCs 0x100,0x200,0x300,0x400 -> fifth pending blocked, intDisable=1; four retis return 0x400,0x300,0x200,0x100 in order. Without macro: second entry blocked until reti.
- Simultaneous reti and intPending at level 1 -> RETURN first (pcOut=saved PC), entry taken at next qualifying boundary.
- Error/reset: reti at level 0 -> stackErr=1 sticky, no pcLoad; rstN=0 during VECTOR -> no pcLoad, all outputs 0 next cycle.

Source files
------------

// File: rtl/hvpi_int_seq_pkg.sv
// Interrupt sequencer shared types.
// FSM state encoding and register reset values.
package hvpi_int_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_VECTOR,
    ST_RETURN
  } seqState_t;

  localparam seqState_t RST_STATE = ST_IDLE;
  localparam logic RST_STACK_ERR = 1'b0;

  function automatic logic isBusy(seqState_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/hvpi_int_sequencer_if.sv
// CPU/HPVI-side signal bundle of the interrupt sequencer.
// master drives requests, slave is the sequencer.
interface hvpi_int_sequencer_if #(
  parameter int pcWidth      = 16,
  parameter int stackAddrLen = 2
);
  logic               intPending;
  logic [pcWidth-1:0] intAddr;
  logic               gie;
  logic               instrDone;
  logic [pcWidth-1:0] pcIn;
  logic               reti;

  logic                stall;
  logic                pcLoad;
  logic [pcWidth-1:0]  pcOut;
  logic                intAck;
  logic                intDisable;
  logic                inIsr;
  logic [stackAddrLen:0] nestLevel;
  logic                stackErr;

  modport master (
    output intPending, intAddr, gie,
    output instrDone, pcIn, reti,
    input  stall, pcLoad, pcOut, intAck,
    input  intDisable, inIsr, nestLevel,
    input  stackErr
  );

  modport slave (
    input  intPending, intAddr, gie,
    input  instrDone, pcIn, reti,
    output stall, pcLoad, pcOut, intAck,
    output intDisable, inIsr, nestLevel,
    output stackErr
  );
endinterface

// File: rtl/hvpi_ret_stack.sv
// Return-address LIFO; top entry visible on dataOut.
// Depth 1 collapses to a single register.
module hvpi_ret_stack #(
  parameter  int pcWidth    = 16,
  parameter  int stackDepth = 4,
  localparam int lvlW       = $clog2(stackDepth) + 1
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               push,
  input  logic               pop,
  input  logic [pcWidth-1:0] dataIn,
  output logic [pcWidth-1:0] dataOut,
  output logic [lvlW-1:0]    level,
  output logic               full,
  output logic               empty
);

  logic [lvlW-1:0] lvl;

  assign level = lvl;
  assign full  = lvl == lvlW'(stackDepth);
  assign empty = lvl == '0;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      lvl <= '0;
    end else if (push && !full) begin
      lvl <= lvl + lvlW'(1);
    end else if (pop && !empty) begin
      lvl <= lvl - lvlW'(1);
    end
  end

  generate
    if (stackDepth == 1) begin : gOne
      logic [pcWidth-1:0] slot;

      always_ff @(posedge clk) begin
        if (!rstN) begin
          slot <= '0;
        end else if (push && !full) begin
          slot <= dataIn;
        end
      end

      assign dataOut = empty ? '0 : slot;
    end else begin : gMem
      localparam int aw = lvlW - 1;

      logic [pcWidth-1:0] mem [stackDepth];
      logic [aw-1:0]      wrIdx;
      logic [aw-1:0]      rdIdx;

      // wraps to depth-1 when full, which is the top slot
      assign wrIdx = lvl[aw-1:0];
      assign rdIdx = wrIdx - aw'(1);

      always_ff @(posedge clk) begin
        if (push && !full) begin
          mem[wrIdx] <= dataIn;
        end
      end

      assign dataOut = empty ? '0 : mem[rdIdx];
    end
  endgenerate

endmodule

// File: rtl/hvpi_int_sequencer.sv
// Interrupt entry/exit sequencer behind the HPVI block.
// INT_NEST_EN enables nesting up to stackDepth levels.
module hvpi_int_sequencer
  import hvpi_int_seq_pkg::*;
#(
  parameter int pcWidth      = 16,
  parameter int stackDepth   = 4,
  parameter int stackAddrLen = 2
) (
  input logic clk,
  input logic rstN,
  hvpi_int_sequencer_if.slave bus
);

`ifdef INT_NEST_EN
  localparam int effDepth = stackDepth;
`else
  localparam int effDepth = 1;
`endif
  localparam int lvlW = $clog2(effDepth) + 1;
  localparam int nlW  = stackAddrLen + 1;

  seqState_t state;
  seqState_t stateNext;

  logic [pcWidth-1:0] vecReg;
  logic [pcWidth-1:0] vecNext;
  logic [pcWidth-1:0] retReg;
  logic [pcWidth-1:0] retNext;
  logic               errReg;
  logic               errNext;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [pcWidth-1:0] topData;
  logic [lvlW-1:0]    level;

  logic               busy;
  logic               intDisable;
  logic               qualify;
  logic [nlW-1:0]     nestLevel;
  logic [pcWidth-1:0] pcOutC;

  hvpi_ret_stack #(
    .pcWidth   (pcWidth),
    .stackDepth(effDepth)
  ) uStack (
    .clk    (clk),
    .rstN   (rstN),
    .push   (push),
    .pop    (pop),
    .dataIn (retReg),
    .dataOut(topData),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  assign busy      = isBusy(state);
  assign nestLevel = nlW'(level);

`ifdef INT_NEST_EN
  assign intDisable = busy ||
    (nestLevel == nlW'(stackDepth));
`else
  assign intDisable = busy || !empty;
`endif

  assign qualify = bus.intPending &&
                   bus.gie &&
                   bus.instrDone &&
                   !intDisable;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= RST_STATE;
      vecReg <= '0;
      retReg <= '0;
      errReg <= RST_STACK_ERR;
    end else begin
      state  <= stateNext;
      vecReg <= vecNext;
      retReg <= retNext;
      errReg <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    vecNext   = vecReg;
    retNext   = retReg;
    errNext   = errReg;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // a return always beats a new entry
        if (bus.reti) begin
          if (!empty) begin
            stateNext = ST_RETURN;
          end else begin
            errNext = 1'b1;
          end
        end else if (qualify) begin
          stateNext = ST_ACK;
          vecNext   = bus.intAddr;
          retNext   = bus.pcIn;
        end
      end
      ST_ACK: begin
        push      = !full;
        stateNext = ST_VECTOR;
      end
      ST_VECTOR: begin
        stateNext = ST_IDLE;
      end
      ST_RETURN: begin
        pop       = 1'b1;
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pcOutC = '0;
    unique case (1'b1)
      (state == ST_VECTOR): pcOutC = vecReg;
      (state == ST_RETURN): pcOutC = topData;
      default:              pcOutC = '0;
    endcase
  end

  assign bus.stall      = busy;
  assign bus.intAck     = state == ST_ACK;
  assign bus.pcLoad     = (state == ST_VECTOR) ||
                          (state == ST_RETURN);
  assign bus.pcOut      = pcOutC;
  assign bus.intDisable = intDisable;
  assign bus.inIsr      = !empty;
  assign bus.nestLevel  = nestLevel;
  assign bus.stackErr   = errReg;

endmodule
